uart_rx_ctrl: RTL and testbench

//  Bus-facing controller for the UART receive port. Owns the baud compare register that configures the port.

---
 rtl/uart_rx_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/uart_rx_ctrl.sv
// Bus-facing receive controller: baud register, DEPTH-entry receive FIFO, status/control registers, level irq.
// Optional idle timeout (sticky TO flag) is built when UART_RX_TIMEOUT_EN is defined.
module uart_rx_ctrl #(
   parameter int          DEPTH    = 8,
   parameter logic [15:0] BAUD_RST = 16'd867
) (
   input  logic        CLK,
   input  logic        resetn,
   input  logic        sel,
   input  logic        we,
   input  logic [1:0]  addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic [15:0] baudcmp,
   input  logic [7:0]  rx_data,
   input  logic        rx_vaild,
   output logic        rx_ready,
   output logic        irq
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = AW + 1;

   logic [7:0]    mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [15:0]   baud_q, baud_d;
   logic          en_q, en_d;
   logic          ie_q, ie_d;
   logic          ovr_q, ovr_d;
   logic [31:0]   rdata_q, rdata_d;
   logic          irq_q, irq_d;

   logic rd_s, wr_s, empty_s, full_s, pop_s, push_s, flush_s, ovr_set_s;
   logic to_s, to_nxt_s;
   logic [31:0] status_s;

   assign rd_s      = sel & ~we;
   assign wr_s      = sel & we;
   assign empty_s   = (count_q == CW'(0));
   assign full_s    = (count_q == CW'(DEPTH));
   assign pop_s     = rd_s & (addr == 2'd0) & ~empty_s;
   assign flush_s   = wr_s & (addr == 2'd3) & wdata[2];
   // A pop in the same cycle frees a slot, so a full FIFO still accepts the byte.
   assign push_s    = rx_vaild & en_q & (~full_s | pop_s);
   assign ovr_set_s = rx_vaild & en_q & full_s & ~pop_s;
   assign status_s  = {16'h0000, 8'(count_q), 4'h0, to_s, ovr_q, full_s, ~empty_s};

`ifdef UART_RX_TIMEOUT_EN
   logic        to_q, to_d;
   logic [21:0] idle_q, idle_d;
   logic [21:0] limit_s;
   logic        idle_clr_s, to_set_s;

   assign limit_s    = ({6'b000000, baud_q} + 22'd1) * 22'd40;
   assign idle_clr_s = push_s | pop_s | flush_s | empty_s;
   // Set only on the crossing so a software clear sticks while the counter holds.
   assign to_set_s   = ~idle_clr_s & (idle_q == limit_s - 22'd1);

   // Idle counter and sticky timeout flag next-state.
   always_comb begin
      idle_d = idle_q;
      to_d   = to_q;
      if (idle_clr_s) begin
         idle_d = 22'd0;
      end else if (idle_q < limit_s) begin
         idle_d = idle_q + 22'd1;
      end else begin
         idle_d = idle_q;
      end
      if (to_set_s) begin
         to_d = 1'b1;
      end else if (wr_s && (addr == 2'd1) && wdata[3]) begin
         to_d = 1'b0;
      end else begin
         to_d = to_q;
      end
   end

   // Timeout state registers.
   always_ff @(posedge CLK) begin
      if (!resetn) begin
         idle_q <= 22'd0;
         to_q   <= 1'b0;
      end else begin
         idle_q <= idle_d;
         to_q   <= to_d;
      end
   end

   assign to_s     = to_q;
   assign to_nxt_s = to_d;
`else
   assign to_s     = 1'b0;
   assign to_nxt_s = 1'b0;
`endif

   // FIFO, register file and read-data next-state.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      baud_d   = baud_q;
      en_d     = en_q;
      ie_d     = ie_q;
      ovr_d    = ovr_q;
      rdata_d  = rdata_q;

      if (flush_s) begin
         wr_ptr_d = AW'(0);
         rd_ptr_d = AW'(0);
         count_d  = CW'(0);
      end else begin
         if (push_s) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
         end else begin
            wr_ptr_d = wr_ptr_q;
         end
         if (pop_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
         end else begin
            rd_ptr_d = rd_ptr_q;
         end
         case ({push_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end

      if (wr_s && (addr == 2'd2)) begin
         baud_d = wdata[15:0];
      end else begin
         baud_d = baud_q;
      end
      if (wr_s && (addr == 2'd3)) begin
         en_d = wdata[0];
         ie_d = wdata[1];
      end else begin
         en_d = en_q;
         ie_d = ie_q;
      end
      if (ovr_set_s) begin
         ovr_d = 1'b1;
      end else if (wr_s && (addr == 2'd1) && wdata[2]) begin
         ovr_d = 1'b0;
      end else begin
         ovr_d = ovr_q;
      end

      if (rd_s) begin
         case (addr)
            2'd0:    rdata_d = empty_s ? 32'h0000_0000 : {24'h000000, mem_q[rd_ptr_q]};
            2'd1:    rdata_d = status_s;
            2'd2:    rdata_d = {16'h0000, baud_q};
            2'd3:    rdata_d = {30'h0000_0000, ie_q, en_q};
            default: rdata_d = 32'h0000_0000;
         endcase
      end else begin
         rdata_d = rdata_q;
      end
   end

   assign irq_d = ie_d & ((count_d != CW'(0)) | ovr_d | to_nxt_s);

   // FIFO storage; contents need no reset because the pointers define validity.
   always_ff @(posedge CLK) begin
      if (push_s) begin
         mem_q[wr_ptr_q] <= rx_data;
      end
   end

   // Control, status and output registers.
   always_ff @(posedge CLK) begin
      if (!resetn) begin
         wr_ptr_q <= AW'(0);
         rd_ptr_q <= AW'(0);
         count_q  <= CW'(0);
         baud_q   <= BAUD_RST;
         en_q     <= 1'b0;
         ie_q     <= 1'b0;
         ovr_q    <= 1'b0;
         rdata_q  <= 32'h0000_0000;
         irq_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         baud_q   <= baud_d;
         en_q     <= en_d;
         ie_q     <= ie_d;
         ovr_q    <= ovr_d;
         rdata_q  <= rdata_d;
         irq_q    <= irq_d;
      end
   end

   assign rdata    = rdata_q;
   assign baudcmp  = baud_q;
   assign irq      = irq_q;
   assign rx_ready = 1'b1;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Scoreboard bench for uart_rx_ctrl: bus reads queue their expected rdata, a monitor compares on return.
module tb_uart_rx_ctrl;

   logic        CLK = 1'b0;
   logic        resetn, sel, we, rx_vaild;
   logic [1:0]  addr;
   logic [31:0] wdata;
   logic [7:0]  rx_data;
   logic [31:0] rdata;
   logic [15:0] baudcmp;
   logic        rx_ready, irq;

   int n_chk  = 0;
   int n_pass = 0;
   logic [31:0] exp_q [$];

   uart_rx_ctrl #(.DEPTH(8), .BAUD_RST(16'd867)) dut (
      .CLK(CLK), .resetn(resetn), .sel(sel), .we(we), .addr(addr), .wdata(wdata),
      .rdata(rdata), .baudcmp(baudcmp), .rx_data(rx_data), .rx_vaild(rx_vaild),
      .rx_ready(rx_ready), .irq(irq)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
   endtask

   task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
      sel = 1'b1; we = 1'b1; addr = a; wdata = d;
      @(negedge CLK);
      sel = 1'b0; we = 1'b0; wdata = 32'h0;
   endtask

   task automatic bus_read(input logic [1:0] a, input logic [31:0] exp);
      sel = 1'b1; we = 1'b0; addr = a;
      exp_q.push_back(exp);
      @(negedge CLK);
      sel = 1'b0;
   endtask

   task automatic push(input logic [7:0] b);
      rx_vaild = 1'b1; rx_data = b;
      @(negedge CLK);
      rx_vaild = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge CLK);
   endtask

   // Monitor: a read accepted at a posedge returns rdata by the following negedge.
   initial begin : monitor
      logic fire;
      logic [31:0] e;
      forever begin
         @(posedge CLK);
         fire = sel && !we && resetn;
         @(negedge CLK);
         if (fire) begin
            if (exp_q.size() == 0) begin
               n_chk++;
               $display("FAIL unexpected_read: got 0x%08h expected no read", rdata);
            end else begin
               e = exp_q.pop_front();
               check("read", rdata, e);
            end
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "bench did not complete");
   end

   initial begin : stim
      logic [31:0] last;
      resetn = 1'b0; sel = 1'b0; we = 1'b0; addr = 2'd0; wdata = 32'h0;
      rx_vaild = 1'b0; rx_data = 8'h00;
      idle(2);
      check("rst_baudcmp", {16'h0, baudcmp}, 32'd867);
      check("rst_rdata", rdata, 32'h0);
      check("rst_irq", {31'h0, irq}, 32'h0);
      check("rst_rx_ready", {31'h0, rx_ready}, 32'h1);
      resetn = 1'b1;
      bus_read(2'd1, 32'h0000_0000);
      bus_read(2'd0, 32'h0000_0000);

      // basic push / read
      bus_write(2'd3, 32'h3);
      push(8'hA5);
      idle(1);
      bus_read(2'd1, 32'h0000_0101);
      check("irq_ne", {31'h0, irq}, 32'h1);
      bus_read(2'd0, 32'h0000_00A5);
      bus_read(2'd1, 32'h0000_0000);
      idle(1);
      check("irq_clear", {31'h0, irq}, 32'h0);

      // overrun
      for (int i = 0; i < 9; i++) push(8'(i));
      bus_read(2'd1, 32'h0000_0807);
      check("irq_full", {31'h0, irq}, 32'h1);
      for (int i = 0; i < 8; i++) bus_read(2'd0, 32'(i));
      bus_read(2'd1, 32'h0000_0004);
      bus_write(2'd1, 32'h4);
      bus_read(2'd1, 32'h0000_0000);

      // full FIFO with push and pop in the same cycle
      for (int i = 0; i < 8; i++) push(8'(8'h10 + i));
      rx_vaild = 1'b1; rx_data = 8'h55;
      bus_read(2'd0, 32'h0000_0010);
      rx_vaild = 1'b0;
      bus_read(2'd1, 32'h0000_0803);
      for (int i = 1; i < 8; i++) bus_read(2'd0, 32'(8'h10 + i));
      bus_read(2'd0, 32'h0000_0055);
      bus_read(2'd1, 32'h0000_0000);

      // configuration
      bus_write(2'd2, 32'hFFFF_0010);
      check("baudcmp_upd", {16'h0, baudcmp}, 32'h0000_0010);
      bus_read(2'd2, 32'h0000_0010);
      bus_write(2'd3, 32'h2);
      push(8'h33);
      bus_read(2'd1, 32'h0000_0000);
      bus_read(2'd3, 32'h0000_0002);
      bus_write(2'd3, 32'h1);
      push(8'h44);
      bus_read(2'd1, 32'h0000_0101);
      rx_vaild = 1'b1; rx_data = 8'h66;
      bus_write(2'd3, 32'h5);
      rx_vaild = 1'b0;
      bus_read(2'd1, 32'h0000_0000);
      bus_read(2'd0, 32'h0000_0000);
      bus_read(2'd3, 32'h0000_0001);
      idle(1);
      last = rdata;
      bus_write(2'd2, 32'h0000_0020);
      check("write_keeps_rdata", rdata, 32'h0000_0001);

      // reset mid-operation with a byte presented
      push(8'h77);
      resetn = 1'b0; rx_vaild = 1'b1; rx_data = 8'h99;
      idle(1);
      resetn = 1'b1; rx_vaild = 1'b0;
      check("rst2_baudcmp", {16'h0, baudcmp}, 32'd867);
      check("rst2_irq", {31'h0, irq}, 32'h0);
      bus_read(2'd1, 32'h0000_0000);
      bus_read(2'd3, 32'h0000_0000);

`ifdef UART_RX_TIMEOUT_EN
      bus_write(2'd2, 32'h9);
      bus_write(2'd3, 32'h3);
      push(8'hC3);
      idle(399);
      bus_read(2'd1, 32'h0000_0101);
      bus_read(2'd1, 32'h0000_0109);
      check("irq_to", {31'h0, irq}, 32'h1);
      bus_write(2'd1, 32'h8);
      bus_read(2'd1, 32'h0000_0101);
`endif

      for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge CLK);
      idle(2);
      if (exp_q.size() != 0) begin
         n_chk++;
         $display("FAIL pending_reads: got %0d outstanding expected 0", exp_q.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
